lsu_bridge: RTL

Load/store bridge between the CPU core's data port and the word-only system memory (1024 × 32-bit, write-enable per word, registered read address, data valid the cycle after the address). It accepts one byte/halfword/word request at a time, with a valid/ready handshake. Loads are served with lane extraction and sign/zero extension. Sub-word stores run as a two-cycle read-modify-write. Misaligned requests are rejected with an error response and never touch memory.

---
 rtl/lsu_bridge_if.sv | 30 +++
 rtl/lsu_bridge.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/lsu_bridge_if.sv
// CPU request/response and word-memory signal bundle for the load/store bridge.
// The bridge takes the slave modport; the CPU/memory side takes the master modport.
interface lsu_bridge_if #(
  parameter int unsigned AW = 10
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/lsu_bridge.sv
// Byte/half/word load-store bridge onto a word-only memory with a registered read address.
// Sub-word stores are a read-modify-write; misaligned requests return an error response.
module lsu_bridge #(
  parameter int unsigned AW = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  lsu_bridge_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StLd, StRmw} state_e;

  state_e        r_state, w_state_next;
  logic [AW-1:0] r_waddr, w_waddr_next;
  logic [1:0]    r_off, w_off_next;
  logic [1:0]    r_size, w_size_next;
  logic          r_unsigned, w_unsigned_next;
  logic [15:0]   r_wdata, w_wdata_next;
  logic          r_rsp_valid, w_rsp_valid_next;
  logic [31:0]   r_rsp_rdata, w_rsp_rdata_next;
  logic          r_rsp_err, w_rsp_err_next;

  logic          w_ready, w_accept, w_misalign;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_din;
  logic [31:0]   w_shift, w_load, w_merge;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [4:0]    w_bitoff;
  logic          w_unused_addr;

  assign w_unused_addr = ^io_bus.req_addr[31:AW+2];

  assign w_ready    = (r_state == StIdle) & ~i_rst;
  assign w_accept   = io_bus.req_valid & w_ready;
  assign w_misalign = (io_bus.req_size == 2'b11) ||
                      (io_bus.req_size == 2'b01 && io_bus.req_addr[0]) ||
                      (io_bus.req_size == 2'b10 && io_bus.req_addr[1:0] != 2'b00);

  // Lane extraction and merge both work on the captured byte offset.
  assign w_bitoff = {r_off, 3'b000};
  assign w_shift  = io_bus.mem_dout >> w_bitoff;
  assign w_byte   = w_shift[7:0];
  assign w_half   = r_off[1] ? io_bus.mem_dout[31:16] : io_bus.mem_dout[15:0];

  always_comb begin
    w_load  = io_bus.mem_dout;
    w_merge = io_bus.mem_dout;
    if (r_size == 2'b00) begin
      w_load  = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      w_merge = (io_bus.mem_dout & ~(32'h0000_00FF << w_bitoff)) |
                ({24'h0, r_wdata[7:0]} << w_bitoff);
    end else if (r_size == 2'b01) begin
      w_load  = {{16{~r_unsigned & w_half[15]}}, w_half};
      w_merge = r_off[1] ? {r_wdata, io_bus.mem_dout[15:0]} : {io_bus.mem_dout[31:16], r_wdata};
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_waddr_next     = r_waddr;
    w_off_next       = r_off;
    w_size_next      = r_size;
    w_unsigned_next  = r_unsigned;
    w_wdata_next     = r_wdata;
    w_rsp_valid_next = 1'b0;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_err_next   = r_rsp_err;
    w_mem_we         = 1'b0;
    w_mem_addr       = '0;
    w_mem_din        = '0;
    unique case (r_state)
      StIdle: begin
        w_mem_addr = io_bus.req_addr[AW+1:2];
        if (w_accept) begin
          if (w_misalign) begin
            w_rsp_valid_next = 1'b1;
            w_rsp_rdata_next = '0;
            w_rsp_err_next   = 1'b1;
          end else if (io_bus.req_we && io_bus.req_size == 2'b10) begin
            w_mem_we         = 1'b1;
            w_mem_din        = io_bus.req_wdata;
            w_rsp_valid_next = 1'b1;
            w_rsp_rdata_next = '0;
            w_rsp_err_next   = 1'b0;
          end else begin
            w_waddr_next    = io_bus.req_addr[AW+1:2];
            w_off_next      = io_bus.req_addr[1:0];
            w_size_next     = io_bus.req_size;
            w_unsigned_next = io_bus.req_unsigned;
            w_wdata_next    = io_bus.req_wdata[15:0];
            w_state_next    = io_bus.req_we ? StRmw : StLd;
          end
        end
      end
      StLd: begin
        w_mem_addr       = r_waddr;
        w_rsp_valid_next = 1'b1;
        w_rsp_rdata_next = w_load;
        w_rsp_err_next   = 1'b0;
        w_state_next     = StIdle;
      end
      StRmw: begin
        w_mem_addr       = r_waddr;
        w_mem_we         = 1'b1;
        w_mem_din        = w_merge;
        w_rsp_valid_next = 1'b1;
        w_rsp_rdata_next = '0;
        w_rsp_err_next   = 1'b0;
        w_state_next     = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_waddr     <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_waddr     <= w_waddr_next;
      r_off       <= w_off_next;
      r_size      <= w_size_next;
      r_unsigned  <= w_unsigned_next;
      r_wdata     <= w_wdata_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_err   <= w_rsp_err_next;
    end
  end

  // Memory-side outputs are forced quiet while reset is held, including the IDLE address path.
  assign io_bus.req_ready = w_ready;
  assign io_bus.mem_we    = w_mem_we & ~i_rst;
  assign io_bus.mem_addr  = i_rst ? '0 : w_mem_addr;
  assign io_bus.mem_din   = i_rst ? '0 : w_mem_din;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_rdata = r_rsp_rdata;
  assign io_bus.rsp_err   = r_rsp_err;

endmodule
